mux_n_pipe: RTL
===============

Name: mux_n_pipe

Overview:
- Parametrised N:1 datapath multiplexer with a registered output stage and a valid/ready handshake.
- Successor to the fixed 16-bit 2:1 mux. Generalised in width and input count, with one cycle of latency and backpressure.
- Sits between register-file/ALU-result sources and pipeline-stage inputs (writeback select, ALU operand select). Stalls propagate upstream through in_ready.

Parameters:
- WIDTH, 16, data width of each input and of the output.
- NUM_IN, 4, number of inputs; legal range 2..16, any value (need not be a power of two).
- SEL_W, derived localparam = $clog2(NUM_IN), select width; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_bus  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  input select, sampled on accept.
- in_valid  input  1  upstream offers sel/in_bus this cycle.
- in_ready  output  1  block can accept this cycle.
- o  output  WIDTH  registered selected data.
- out_sel  output  SEL_W  select value that produced o.
- out_valid  output  1  o/out_sel hold valid data.
- out_ready  input  1  downstream consumes o this cycle.
- sel_err  output  1  registered; high with out_valid when the accepted sel was >= NUM_IN.
- mode  input  1  present only when MUX_RR_EN is defined (see Optional Feature).

Behaviour:
- Reset (asynchronous, immediate): o=0, out_sel=0, out_valid=0, sel_err=0. Round-robin pointer=0.
- in_ready = !out_valid || out_ready. Combinational; no path from in_valid.
- Accept = in_valid && in_ready. On an accept clock edge:
  - o <= in_bus[sel] (0 if sel >= NUM_IN);
  - out_sel <= sel;
  - sel_err <= (sel >= NUM_IN);
  - out_valid <= 1.
- Latency: exactly 1 cycle from accept to out_valid.
- Drain: out_valid && out_ready && !in_valid -> out_valid <= 0. o, out_sel and sel_err hold their last values.
- Simultaneous consume and accept: the new data replaces the old in the same edge, with no bubble. Full throughput is 1 word per cycle.
- Stall: out_valid && !out_ready -> in_ready=0. o, out_sel and sel_err stay stable. in_bus and sel are ignored.
- Reset asserted mid-transfer: the held word is discarded. out_valid drops asynchronously.
- No combinational path from in_bus to o.

Optional Feature:
- Macro: MUX_RR_EN.
- Defined: mode port exists and an internal SEL_W-bit rr_ptr is added.
  - mode=1: sel is ignored. Each accept uses rr_ptr as the select, then rr_ptr advances by 1 and wraps from NUM_IN-1 to 0. sel_err is never set in this mode.
  - mode=0: the external sel is used as normal; rr_ptr holds its value.
  - Changing mode never resets rr_ptr.
- Undefined: no mode port and no rr_ptr; external sel only. All other behaviour is identical.

Decomposition:
- Shared header mux_defs.vh holds the default WIDTH/NUM_IN constants and the MUX_RR_EN guard comment; the processor top includes it.
- One combinational sub-module, mux_n_comb (parameters WIDTH, NUM_IN; ports in_bus, sel, o, err). It performs the indexed select and the out-of-range zeroing.
- mux_n_pipe owns the handshake, the register stage and rr_ptr.

Test Plan:
All scenarios use WIDTH=16 and NUM_IN=4 unless stated; inputs are in0=0x0001, in1=0x0002, in2=0x0003, in3=0x0004.
1. Basic select: out_ready=1, in_valid=1, sel swept 0..3 over consecutive cycles -> o = 0x0001, 0x0002, 0x0003, 0x0004 appear one cycle later, with out_valid high continuously.
2. Backpressure: accept sel=2, then hold out_ready=0 for 3 cycles while in_valid=1 with sel=1 -> in_ready=0, o stays 0x0003. Release out_ready -> next cycle o=0x0002.
3. Out of range (NUM_IN=3): sel=3 accepted -> o=0x0000, sel_err=1, out_sel=3. Next accept with sel=0 -> sel_err=0, o=0x0001.
4. Reset mid-stall: out_valid=1, out_ready=0; pulse reset between clock edges -> out_valid, o and sel_err go to 0 immediately, and in_ready=1 afterwards.
5. MUX_RR_EN defined: mode=1, 6 accepts -> out_sel sequence 0,1,2,3,0,1. Switch to mode=0 with sel=3 -> o=0x0004. Switch back to mode=1 -> out_sel=2.
6. Drain: a single accept followed by in_valid=0 and out_ready=1 -> out_valid high for exactly one cycle, then 0, with o held.

Source files
------------

// File: rtl/mux_n_pipe_pkg.sv
// Shared constants for the N:1 pipelined mux: default geometry and the
// select-source encoding used by the optional round-robin mode.
package mux_n_pipe_pkg;

    // Default data width and input count used when a parent does not override.
    localparam int DEF_WIDTH  = 16;
    localparam int DEF_NUM_IN = 4;

    // Legal input-count range for NUM_IN.
    localparam int NUM_IN_MIN = 2;
    localparam int NUM_IN_MAX = 16;

    // Where the select for an accepted word comes from.
    typedef enum logic {
        SEL_EXT = 1'b0,  // external sel port
        SEL_RR  = 1'b1   // internal round-robin pointer
    } sel_mode_e;

endpackage

// File: rtl/mux_n_pipe_comb.sv
// Combinational N:1 select. Codes that match no input drive zero and raise
// err, so a non-power-of-two NUM_IN never reads past the packed bus.
module mux_n_comb #(
    parameter  int WIDTH  = 16,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        o,
    output logic                    err
);

    // Indexed select with out-of-range zeroing.
    always_comb begin
        // NOTE: defaults come first so every path assigns o and err; no latch is inferred.
        o   = '0;
        err = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                o   = in_bus[k*WIDTH +: WIDTH];
                err = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N:1 datapath mux with one registered output stage and a
// valid/ready handshake (one-cycle latency, full throughput, backpressure).
// Optional feature: define MUX_RR_EN to add the mode port and an internal
// round-robin select pointer.
module mux_n_pipe
    import mux_n_pipe_pkg::*;
#(
    parameter  int WIDTH  = DEF_WIDTH,
    parameter  int NUM_IN = DEF_NUM_IN,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        o,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
`ifdef MUX_RR_EN
    ,
    input  logic                    mode
`endif
);

    logic             accept;
    logic [SEL_W-1:0] eff_sel;
    logic [WIDTH-1:0] mux_o;
    logic             mux_err;

    // The stage can take a word when it is empty or its word leaves this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

`ifdef MUX_RR_EN
    logic [SEL_W-1:0] rr_ptr;

    // Select source: round-robin pointer in RR mode, external sel otherwise.
    assign eff_sel = (sel_mode_e'(mode) == SEL_RR) ? rr_ptr : sel;

    // Round-robin pointer advances on each RR-mode accept and wraps at NUM_IN-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (accept && sel_mode_e'(mode) == SEL_RR) begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values, independent of block ordering.
            rr_ptr <= (rr_ptr == SEL_W'(NUM_IN - 1)) ? '0 : rr_ptr + 1'b1;
        end
    end
`else
    // Only the external select exists in this build.
    assign eff_sel = sel;
`endif

    mux_n_comb #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_comb (
        .in_bus (in_bus),
        .sel    (eff_sel),
        .o      (mux_o),
        .err    (mux_err)
    );

    // Output stage: load on accept, clear valid on drain, hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o         <= '0;
            out_sel   <= '0;
            sel_err   <= 1'b0;
            out_valid <= 1'b0;
        end else if (accept) begin
            o         <= mux_o;
            out_sel   <= eff_sel;
            sel_err   <= mux_err;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
